// File: rtl/lock_pkg.sv
// Shared state encoding, key codes and helpers for the combination-lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_PROG,
        ST_PCHK,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] KEY_PROG   = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam logic [3:0] KEY_ENTER  = 4'hE;

    localparam logic [2:0] FULL_CODE  = 3'd4;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module lock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Combination-lock sequencer: feeds the external code shift register, checks the code
// against the stored password, and drives unlock/error/alarm and password programming.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] PASSWORD       = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [15:0] code_i,
    output logic        sr_load,
    output logic [3:0]  sr_data,
    output logic        sr_clr,
    output logic        unlock,
    output logic        error,
    output logic        alarm,
    output logic        prog_done,
    output logic [2:0]  tries
);

    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         MAX_T        = 3'(MAX_TRIES);

    state_t       state, state_n;
    logic         check_phase, check_phase_n;
    logic         start_clr;
    logic [2:0]   digit_cnt, digit_cnt_n;
    logic [2:0]   tries_n, tries_inc;
    logic [15:0]  password, password_n;
    logic         sr_load_n, sr_clr_n, unlock_n, error_n, alarm_n, prog_done_n;
    logic [3:0]   sr_data_n;
    logic         fail;
    logic         timer_load, timer_en, timer_zero;
    logic [TIMER_W-1:0] timer_value;

    logic key_digit, key_enter, key_cancel, key_prog, accept_digit;

    assign key_digit    = key_valid && is_digit(key_code);
    assign key_enter    = key_valid && (key_code == KEY_ENTER);
    assign key_cancel   = key_valid && (key_code == KEY_CANCEL);
    assign key_prog     = key_valid && (key_code == KEY_PROG);
    assign accept_digit = key_digit && (digit_cnt < FULL_CODE);
    assign tries_inc    = (tries == MAX_T) ? tries : tries + 3'd1;

    lock_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .clr       (clr),
        .load      (timer_load),
        .load_value(timer_value),
        .enable    (timer_en),
        .zero      (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state       <= ST_IDLE;
            check_phase <= 1'b0;
            start_clr   <= 1'b1;
            digit_cnt   <= '0;
            tries       <= '0;
            password    <= PASSWORD;
            sr_load     <= 1'b0;
            sr_data     <= '0;
            sr_clr      <= 1'b1;
            unlock      <= 1'b0;
            error       <= 1'b0;
            alarm       <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            state       <= state_n;
            check_phase <= check_phase_n;
            start_clr   <= 1'b0;
            digit_cnt   <= digit_cnt_n;
            tries       <= tries_n;
            password    <= password_n;
            sr_load     <= sr_load_n;
            sr_data     <= sr_data_n;
            sr_clr      <= sr_clr_n;
            unlock      <= unlock_n;
            error       <= error_n;
            alarm       <= alarm_n;
            prog_done   <= prog_done_n;
        end
    end

    // The first cycle after reset only flushes the shift register; keys that cycle are dropped.
    always_comb begin
        state_n       = state;
        check_phase_n = 1'b0;
        digit_cnt_n   = digit_cnt;
        tries_n       = tries;
        password_n    = password;
        sr_load_n     = 1'b0;
        sr_data_n     = sr_data;
        sr_clr_n      = 1'b1;
        unlock_n      = unlock;
        error_n       = 1'b0;
        alarm_n       = alarm;
        prog_done_n   = 1'b0;
        fail          = 1'b0;
        timer_load    = 1'b0;
        timer_value   = '0;
        timer_en      = 1'b0;

        if (start_clr) begin
            sr_clr_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (accept_digit) begin
                        sr_load_n   = 1'b1;
                        sr_data_n   = key_code;
                        digit_cnt_n = digit_cnt + 3'd1;
                        state_n     = ST_ENTRY;
                    end else if (key_enter) begin
                        if (digit_cnt == FULL_CODE) begin
                            state_n = ST_CHECK;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (key_cancel && (state == ST_ENTRY)) begin
                        sr_clr_n    = 1'b0;
                        digit_cnt_n = '0;
                        state_n     = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (!check_phase) begin
                        check_phase_n = 1'b1;
                    end else if (code_i == password) begin
                        sr_clr_n    = 1'b0;
                        digit_cnt_n = '0;
                        unlock_n    = 1'b1;
                        tries_n     = '0;
                        timer_load  = 1'b1;
                        timer_value = UNLOCK_LOAD;
                        state_n     = ST_OPEN;
                    end else begin
                        fail = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (timer_zero || key_cancel) begin
                        unlock_n = 1'b0;
                        state_n  = ST_IDLE;
                    end else if (key_prog) begin
                        sr_clr_n    = 1'b0;
                        digit_cnt_n = '0;
                        state_n     = ST_PROG;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                ST_PROG: begin
                    if (accept_digit) begin
                        sr_load_n   = 1'b1;
                        sr_data_n   = key_code;
                        digit_cnt_n = digit_cnt + 3'd1;
                    end else if (key_enter && (digit_cnt == FULL_CODE)) begin
                        state_n = ST_PCHK;
                    end else if (key_enter || key_cancel) begin
                        error_n     = 1'b1;
                        sr_clr_n    = 1'b0;
                        digit_cnt_n = '0;
                        unlock_n    = 1'b0;
                        state_n     = ST_IDLE;
                    end
                end
                ST_PCHK: begin
                    password_n  = code_i;
                    prog_done_n = 1'b1;
                    sr_clr_n    = 1'b0;
                    digit_cnt_n = '0;
                    unlock_n    = 1'b0;
                    state_n     = ST_IDLE;
                end
                ST_LOCKOUT: begin
                    if (timer_zero) begin
                        alarm_n = 1'b0;
                        tries_n = '0;
                        state_n = ST_IDLE;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase

            // Short codes and mismatches share one failure path so lockout treats them alike.
            if (fail) begin
                error_n     = 1'b1;
                sr_clr_n    = 1'b0;
                digit_cnt_n = '0;
                tries_n     = tries_inc;
                if (tries_inc == MAX_T) begin
                    alarm_n     = 1'b1;
                    timer_load  = 1'b1;
                    timer_value = LOCKOUT_LOAD;
                    state_n     = ST_LOCKOUT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller with a behavioural code shift register on the sr_* outputs.
module tb_lock_controller;

    localparam logic [3:0] K_PROG   = 4'hA;
    localparam logic [3:0] K_CANCEL = 4'hC;
    localparam logic [3:0] K_ENTER  = 4'hE;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] code_reg = '0;
    logic        sr_load, sr_clr, unlock, error, alarm, prog_done;
    logic [3:0]  sr_data;
    logic [2:0]  tries;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    logic [3:0] load_q[$];
    logic [3:0] exp_data;

    lock_controller #(
        .PASSWORD      (16'h1234),
        .MAX_TRIES     (3),
        .UNLOCK_CYCLES (8),
        .LOCKOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .key_valid(key_valid),
        .key_code (key_code),
        .code_i   (code_reg),
        .sr_load  (sr_load),
        .sr_data  (sr_data),
        .sr_clr   (sr_clr),
        .unlock   (unlock),
        .error    (error),
        .alarm    (alarm),
        .prog_done(prog_done),
        .tries    (tries)
    );

    always #5 clk = ~clk;

    // Digits shift in at [3:0], so typing 1,2,3,4 reads back as 16'h1234.
    always @(posedge clk) begin
        if (!sr_clr) code_reg <= '0;
        else if (sr_load) code_reg <= {code_reg[11:0], sr_data};
    end

    always @(negedge clk) begin
        if (sr_load === 1'b1) begin
            checks++;
            if (load_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_load got data %0h, expected no load", sr_data);
            end else begin
                exp_data = load_q.pop_front();
                if (sr_data !== exp_data || sr_clr !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL load_data got %0h clr %b, expected %0h clr 1", sr_data, sr_clr, exp_data);
                end
            end
        end
        if (error === 1'b1) err_cnt++;
        if (sr_clr === 1'b0) clr_cnt++;
        if (prog_done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired, simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic push_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) load_q.push_back(c[i*4 +: 4]);
    endtask

    task automatic press_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    task automatic wait_unlock(input string name);
        int n = 0;
        while (unlock !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (unlock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s unlock got %b, expected 1 within 20 cycles", name, unlock);
        end
    endtask

    task automatic wait_error(input string name);
        int n = 0;
        while (error !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s error got %b, expected pulse within 20 cycles", name, error);
        end
    endtask

    task automatic open_with(input logic [15:0] c, input string name);
        push_code(c);
        press_code(c);
        press(K_ENTER);
        wait_unlock(name);
    endtask

    task automatic check_tries(input logic [2:0] exp, input string name);
        checks++;
        if (tries !== exp) begin
            errors++;
            $display("[TB] FAIL %s tries got %0d, expected %0d", name, tries, exp);
        end
    endtask

    task automatic close_lock(input string name);
        press(K_CANCEL);
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s close got unlock %b, expected 0", name, unlock);
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sr_load, unlock, error, alarm, prog_done} !== 5'b0 || sr_data !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b data %0h, expected 00000 data 0",
                     {sr_load, unlock, error, alarm, prog_done}, sr_data);
        end
        check_tries(3'd0, "reset");
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (sr_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_clr_pulse got %b, expected 0", sr_clr);
        end
        @(negedge clk);
        checks++;
        if (sr_clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_clr_end got %b, expected 1", sr_clr);
        end
    endtask

    task automatic test_unlock();
        int n = 0;
        int c0 = clr_cnt;
        open_with(16'h1234, "unlock");
        while (unlock === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (n != 8) begin
            errors++;
            $display("[TB] FAIL unlock_width got %0d cycles, expected 8", n);
        end
        check_tries(3'd0, "unlock");
        checks++;
        if (clr_cnt - c0 != 1) begin
            errors++;
            $display("[TB] FAIL unlock_clr got %0d pulses, expected 1", clr_cnt - c0);
        end
    endtask

    task automatic test_lockout();
        int n = 0;
        for (int a = 1; a <= 3; a++) begin
            push_code(16'h9999);
            press_code(16'h9999);
            press(K_ENTER);
            wait_error("lockout_attempt");
            check_tries(3'(a), "lockout_attempt");
        end
        for (int i = 0; i < 40; i++) begin
            if (alarm !== 1'b1) break;
            n++;
            key_valid = (i < 5);
            key_code  = 4'd7;
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL alarm_width got %0d cycles, expected 16", n);
        end
        check_tries(3'd0, "after_lockout");
    endtask

    task automatic test_short_code();
        int e0 = err_cnt;
        int c0 = clr_cnt;
        load_q.push_back(4'd1);
        load_q.push_back(4'd2);
        press(4'd1);
        press(4'd2);
        press(K_ENTER);
        @(negedge clk);
        #1;
        checks++;
        if (err_cnt - e0 != 1 || clr_cnt - c0 != 1 || unlock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_code got err %0d clr %0d unlock %b, expected 1 1 0",
                     err_cnt - e0, clr_cnt - c0, unlock);
        end
        check_tries(3'd1, "short_code");
        push_code(16'h1234);
        press_code(16'h1234);
        press(4'd5);
        press(K_ENTER);
        wait_unlock("fifth_digit");
        check_tries(3'd0, "fifth_digit");
        close_lock("fifth_digit");
    endtask

    task automatic test_program();
        int n = 0;
        open_with(16'h1234, "prog_open");
        press(K_PROG);
        checks++;
        if (sr_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_enter_clr got %b, expected 0", sr_clr);
        end
        push_code(16'h5678);
        press_code(16'h5678);
        press(K_ENTER);
        checks++;
        if (unlock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prog_hold_unlock got %b, expected 1", unlock);
        end
        while (prog_done !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (prog_done !== 1'b1 || unlock !== 1'b0 || sr_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_done got done %b unlock %b clr %b, expected 1 0 0",
                     prog_done, unlock, sr_clr);
        end
        push_code(16'h1234);
        press_code(16'h1234);
        press(K_ENTER);
        wait_error("old_code");
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL old_code unlock got %b, expected 0", unlock);
        end
        check_tries(3'd1, "old_code");
        open_with(16'h5678, "new_code");
        check_tries(3'd0, "new_code");
        close_lock("new_code");
    endtask

    task automatic test_reset_in_prog();
        open_with(16'h5678, "rst_open");
        press(K_PROG);
        load_q.push_back(4'd1);
        load_q.push_back(4'd2);
        press(4'd1);
        press(4'd2);
        checks++;
        if (unlock !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prog_unlock got %b, expected 1", unlock);
        end
        clr = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({sr_load, unlock, error, alarm, prog_done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL prog_reset_outputs got %b, expected 00000",
                     {sr_load, unlock, error, alarm, prog_done});
        end
        check_tries(3'd0, "prog_reset");
        clr = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (sr_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_reset_clr got %b, expected 0", sr_clr);
        end
        @(negedge clk);
        open_with(16'h1234, "password_restored");
        close_lock("password_restored");
    endtask

    task automatic test_check_and_cancel();
        int e0, c0;
        push_code(16'h1234);
        press_code(16'h1234);
        press(K_ENTER);
        press(4'd5);
        wait_unlock("key_in_check");
        close_lock("key_in_check");
        load_q.push_back(4'd1);
        press(4'd1);
        press(K_ENTER);
        @(negedge clk);
        check_tries(3'd1, "pre_cancel");
        load_q.push_back(4'd3);
        load_q.push_back(4'd4);
        press(4'd3);
        press(4'd4);
        e0 = err_cnt;
        c0 = clr_cnt;
        press(K_CANCEL);
        #1;
        checks++;
        if (clr_cnt - c0 != 1 || err_cnt - e0 != 0) begin
            errors++;
            $display("[TB] FAIL cancel got clr %0d err %0d, expected 1 0", clr_cnt - c0, err_cnt - e0);
        end
        check_tries(3'd1, "cancel");
        open_with(16'h1234, "after_cancel");
        check_tries(3'd0, "after_cancel");
        close_lock("after_cancel");
    endtask

    initial begin
        $display("[TB] lock_controller bench start");
        test_reset();
        test_unlock();
        test_lockout();
        test_short_code();
        test_program();
        test_reset_in_prog();
        test_check_and_cancel();
        repeat (3) @(negedge clk);
        checks++;
        if (load_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_loads got %0d left, expected 0", load_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
